// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage sitting directly downstream of the Icache.
// Holds the architectural fetch PC, presents the line-aligned fetch address
// to the Icache, extracts the 32-bit instruction for the current PC from the
// returned 8-byte line, asks the branch predictor for the next PC and queues
// {inst, pc, npc, pred_taken} in a small FIFO that feeds dispatch.
// A ROB recovery redirects the PC, empties the FIFO and cancels the Icache's
// outstanding miss in the same cycle.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   Icache2if_vld_i/data_i Icache line valid for the current address / line
//   if2Icache_addr_o       {pc[63:3],3'b0}
//   if2Icache_flush_o      cancel outstanding Icache miss (= recovery)
//   if2bp_pc_o             current PC to the branch predictor
//   bp2if_taken_i/target_i combinational prediction for if2bp_pc_o
//   rob2if_recover_i       mispredict recovery, redirects to rob2if_target_i
//   id2if_rdy_i            dispatch consumes the FIFO head this cycle
//   if2id_*                FIFO head: valid, inst, pc, predicted npc, taken
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned IQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Icache2if_vld_i,
   input  logic [63:0] Icache2if_data_i,
   output logic [63:0] if2Icache_addr_o,
   output logic        if2Icache_flush_o,
   output logic [63:0] if2bp_pc_o,
   input  logic        bp2if_taken_i,
   input  logic [63:0] bp2if_target_i,
   input  logic        rob2if_recover_i,
   input  logic [63:0] rob2if_target_i,
   input  logic        id2if_rdy_i,
   output logic        if2id_vld_o,
   output logic [31:0] if2id_inst_o,
   output logic [63:0] if2id_pc_o,
   output logic [63:0] if2id_npc_o,
   output logic        if2id_pred_taken_o
);

   localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

   logic [63:0]      pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [31:0] iq_inst  [IQ_DEPTH];
   logic [63:0] iq_pc    [IQ_DEPTH];
   logic [63:0] iq_npc   [IQ_DEPTH];
   logic        iq_taken [IQ_DEPTH];

   logic [31:0] fetch_inst;
   logic [63:0] fetch_npc;
   logic        pop;
   logic        push;

   // Fetch-side datapath, all combinational from pc and inputs.
   always_comb begin
      fetch_inst = pc[2] ? Icache2if_data_i[63:32] : Icache2if_data_i[31:0];
      fetch_npc  = bp2if_taken_i ? bp2if_target_i : pc + 64'd4;
      pop        = if2id_vld_o & id2if_rdy_i;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push       = Icache2if_vld_i & ~rob2if_recover_i & ((count < DEPTH_C) | pop);
   end

   assign if2Icache_addr_o  = {pc[63:3], 3'b000};
   assign if2bp_pc_o        = pc;
   assign if2Icache_flush_o = rob2if_recover_i;

   assign if2id_vld_o        = (count != '0);
   assign if2id_inst_o       = iq_inst[head];
   assign if2id_pc_o         = iq_pc[head];
   assign if2id_npc_o        = iq_npc[head];
   assign if2id_pred_taken_o = iq_taken[head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            iq_inst[i]  <= '0;
            iq_pc[i]    <= '0;
            iq_npc[i]   <= '0;
            iq_taken[i] <= 1'b0;
         end
      end else if (rob2if_recover_i) begin
         // Recovery wins: redirect and squash, ignoring this cycle's push/pop.
         pc    <= rob2if_target_i;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            iq_inst[tail]  <= fetch_inst;
            iq_pc[tail]    <= pc;
            iq_npc[tail]   <= fetch_npc;
            iq_taken[tail] <= bp2if_taken_i;
            tail           <= tail + PTR_W'(1);
            pc             <= fetch_npc;
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly downstream of the Icache. It holds the PC and drives the line-aligned fetch address to the Icache. When a line is returned it extracts one 32-bit instruction, consults the branch predictor for next-PC, and buffers the instruction in a small FIFO feeding dispatch. ROB branch recovery redirects the PC, squashes the FIFO and flushes the Icache's in-flight miss.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
IQ_DEPTH, 4, instruction FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
Icache2if_vld_i  in  1  Icache data valid for current address
Icache2if_data_i  in  64  fetched 8-byte line
if2Icache_addr_o  out  64  fetch address, {pc[63:3],3'b0}
if2Icache_flush_o  out  1  cancel Icache outstanding miss
if2bp_pc_o  out  64  current PC to branch predictor
bp2if_taken_i  in  1  predicted taken for if2bp_pc_o (combinational)
bp2if_target_i  in  64  predicted target
rob2if_recover_i  in  1  mispredict recovery
rob2if_target_i  in  64  correct PC on recovery
id2if_rdy_i  in  1  dispatch accepts head this cycle
if2id_vld_o  out  1  FIFO head valid
if2id_inst_o  out  32  head instruction
if2id_pc_o  out  64  head PC
if2id_npc_o  out  64  head predicted next PC
if2id_pred_taken_o  out  1  head prediction

Behaviour:
- Reset (async, rst=1): pc<=RESET_PC; FIFO head/tail/count<=0; if2id_vld_o=0, if2id_* data=0; if2Icache_flush_o=0.
- One clock; all state on posedge clk. Every output except if2id_* (FIFO head) is combinational from pc and inputs.
- if2Icache_addr_o={pc[63:3],3'b0}; if2bp_pc_o=pc.
- inst = pc[2] ? data[63:32] : data[31:0].
- npc = bp2if_taken_i ? bp2if_target_i : pc+4 (64-bit wrap, no overflow flag).
- pop = if2id_vld_o & id2if_rdy_i.
- push = Icache2if_vld_i & ~rob2if_recover_i & (count<IQ_DEPTH | pop).
- On push: write {inst, pc, npc, bp2if_taken_i} at tail; tail++ mod IQ_DEPTH; pc<=npc.
- No push (miss or full): pc holds; the Icache keeps seeing the same address.
- count: +1 on push only, -1 on pop only, unchanged on both. Simultaneous push and pop when full is legal; count stays IQ_DEPTH.
- if2id_vld_o = (count!=0); the head entry is driven from the register array at head.
- Recovery (rob2if_recover_i=1) has priority over everything:
  - pc<=rob2if_target_i; head, tail and count <=0.
  - Same-cycle pop and push are discarded.
  - if2Icache_flush_o=rob2if_recover_i (combinational, same cycle).
  - Next cycle the fetch address is the target and the FIFO is empty.
- Unaligned pc[1:0] is not checked; bits are carried unchanged.
- rst asserted mid-miss: state returns to reset values immediately. The Icache is reset by the same rst.
- Latency: Icache hit in cycle N -> instruction visible at if2id_* in cycle N+1. Throughput is 1 instruction/cycle.

Test Plan:
1. Reset, RESET_PC=0, vld=1 with data=64'hAAAAAAAA_BBBBBBBB, bp not taken -> cycle1 head inst=32'hBBBBBBBB pc=0 npc=4; next push inst=32'hAAAAAAAA pc=4 npc=8; addr_o then goes 0,0,8.
2. Predicted taken: pc=8, bp2if_taken_i=1, target=64'h100 -> entry npc=64'h100, pred_taken=1; next addr_o=64'h100.
3. Backpressure: id2if_rdy_i=0, vld=1 for 6 cycles -> exactly IQ_DEPTH=4 pushes, pc stalls at 16; then rdy=1 with vld=1 -> one pop and one push per cycle, count stays 4.
4. Miss: vld=0 for 5 cycles at pc=64'h40 -> addr_o stable 64'h40, no push; vld=1 -> push pc=64'h40.
5. Recovery with FIFO holding 3 entries, simultaneous vld=1 and rdy=1, target=64'h200 -> flush_o=1 that cycle, no push or pop effect, next cycle if2id_vld_o=0 and addr_o=64'h200.
6. Async reset asserted mid-cycle while FIFO full -> if2id_vld_o drops immediately, pc=RESET_PC before the next clock edge.
